// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

   // Controller sequencing state.
   typedef enum logic [1:0] {
      HZ_RUN  = 2'd0,
      HZ_WAIT = 2'd1,
      HZ_HALT = 2'd2
   } hz_state_t;

   // E-stage operand mux select.
   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   // result_src encoding that marks a load in E.
   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forward select for one E-stage source register.
// Latency: combinational, same cycle.
// Backpressure: none; pure function of the pipe-register fields.
// Ports: i_rs_e source reg in E; i_rd_m/i_reg_write_m M writer;
//        i_rd_w/i_reg_write_w W writer; o_sel forward select.
module hazard_fwd_sel
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic [REG_ADDR_WIDTH-1:0] i_rs_e,
   input  logic [REG_ADDR_WIDTH-1:0] i_rd_m,
   input  logic                      i_reg_write_m,
   input  logic [REG_ADDR_WIDTH-1:0] i_rd_w,
   input  logic                      i_reg_write_w,
   output fwd_sel_t                  o_sel
);

   // M holds the younger result, so it is checked first. x0 is never forwarded.
   always_comb begin
      o_sel = FWD_RF;
      if (i_reg_write_m && (i_rd_m != '0) && (i_rd_m == i_rs_e)) begin
         o_sel = FWD_M;
      end else if (i_reg_write_w && (i_rd_w != '0) && (i_rd_w == i_rs_e)) begin
         o_sel = FWD_W;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: stall/flush sequencing, forwarding, memory-wait timeout.
// Latency: stall/flush/forward are combinational (same cycle); timeout_o and counters register on clk_i.
// Backpressure: mem_reqM_i && !mem_readyM_i holds F/D/E/M and bubbles W; timeout parks in HALT until reset.
// Ports: rs*/rd* pipe-reg register fields; result_srcE_i load marker; reg_write{M,W}_i writer valids;
//        pc_srcE_i redirect; mem_{req,ready}M_i data memory handshake; stall*/flush* register controls;
//        forward_{a,b}E_o operand selects; timeout_o sticky; stall_cnt_o/flush_cnt_o perf counters.
// Optional feature: define HAZARD_PERF_EN to build the saturating perf counters (otherwise tied to 0).
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int MEM_TIMEOUT    = 64,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [REG_ADDR_WIDTH-1:0] rs1D_i,
   input  logic [REG_ADDR_WIDTH-1:0] rs2D_i,
   input  logic [REG_ADDR_WIDTH-1:0] rs1E_i,
   input  logic [REG_ADDR_WIDTH-1:0] rs2E_i,
   input  logic [REG_ADDR_WIDTH-1:0] rdE_i,
   input  logic [REG_ADDR_WIDTH-1:0] rdM_i,
   input  logic [REG_ADDR_WIDTH-1:0] rdW_i,
   input  logic [1:0]                result_srcE_i,
   input  logic                      reg_writeM_i,
   input  logic                      reg_writeW_i,
   input  logic                      pc_srcE_i,
   input  logic                      mem_reqM_i,
   input  logic                      mem_readyM_i,
   output logic                      stallF_o,
   output logic                      stallD_o,
   output logic                      stallE_o,
   output logic                      stallM_o,
   output logic                      flushD_o,
   output logic                      flushE_o,
   output logic                      flushW_o,
   output logic [1:0]                forward_aE_o,
   output logic [1:0]                forward_bE_o,
   output logic                      timeout_o,
   output logic [CNT_WIDTH-1:0]      stall_cnt_o,
   output logic [CNT_WIDTH-1:0]      flush_cnt_o
);

   localparam int                WCW       = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [WCW-1:0]    WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

   hz_state_t      r_state, w_state_nxt;
   logic [WCW-1:0] r_wait_cnt, w_wait_cnt_nxt;
   logic           r_timeout, w_timeout_set;
   logic           w_mem_wait, w_load_use, w_hold;
   logic           w_stall_fd, w_flush_d, w_flush_e;
   fwd_sel_t       w_fwd_a, w_fwd_b;

   hazard_fwd_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
      .i_rs_e(rs1E_i), .i_rd_m(rdM_i), .i_reg_write_m(reg_writeM_i),
      .i_rd_w(rdW_i), .i_reg_write_w(reg_writeW_i), .o_sel(w_fwd_a)
   );

   hazard_fwd_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
      .i_rs_e(rs2E_i), .i_rd_m(rdM_i), .i_reg_write_m(reg_writeM_i),
      .i_rd_w(rdW_i), .i_reg_write_w(reg_writeW_i), .o_sel(w_fwd_b)
   );

   assign w_mem_wait = mem_reqM_i && !mem_readyM_i;
   assign w_load_use = (result_srcE_i == RESULT_SRC_LOAD) && (rdE_i != '0) &&
                       ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));

   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_timeout_set  = 1'b0;
      w_hold         = 1'b0;
      w_stall_fd     = 1'b0;
      w_flush_d      = 1'b0;
      w_flush_e      = 1'b0;
      case (r_state)
         HZ_RUN, HZ_WAIT: begin
            if (w_mem_wait) begin
               w_hold = 1'b1;
               if (r_state == HZ_RUN) begin
                  w_state_nxt    = HZ_WAIT;
                  w_wait_cnt_nxt = WCW'(1);
               end else begin
                  // Bounded by WAIT_LAST, so the counter cannot wrap.
                  w_wait_cnt_nxt = r_wait_cnt + WCW'(1);
                  if (r_wait_cnt == WAIT_LAST) begin
                     w_timeout_set = 1'b1;
                     w_state_nxt   = HZ_HALT;
                  end
               end
            end else begin
               // Release cycle of a wait behaves exactly like a normal RUN cycle.
               w_state_nxt    = HZ_RUN;
               w_wait_cnt_nxt = '0;
               if (pc_srcE_i) begin
                  // Redirect squashes D, so any load-use victim there is moot.
                  w_flush_d = 1'b1;
                  w_flush_e = 1'b1;
               end else if (w_load_use) begin
                  w_stall_fd = 1'b1;
                  w_flush_e  = 1'b1;
               end
            end
         end
         HZ_HALT: w_hold = 1'b1;
         default: w_state_nxt = HZ_RUN;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= HZ_RUN;
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         if (w_timeout_set) begin
            r_timeout <= 1'b1;
         end
      end
   end

   // Reset forces a clean bubble through D/E/W regardless of inputs.
   assign stallF_o     = !rst_i && (w_hold || w_stall_fd);
   assign stallD_o     = !rst_i && (w_hold || w_stall_fd);
   assign stallE_o     = !rst_i && w_hold;
   assign stallM_o     = !rst_i && w_hold;
   assign flushD_o     = rst_i || w_flush_d;
   assign flushE_o     = rst_i || w_flush_e;
   assign flushW_o     = rst_i || w_hold;
   assign forward_aE_o = rst_i ? FWD_RF : w_fwd_a;
   assign forward_bE_o = rst_i ? FWD_RF : w_fwd_b;
   assign timeout_o    = r_timeout;

`ifdef HAZARD_PERF_EN
   logic [CNT_WIDTH-1:0] r_stall_cnt, r_flush_cnt;

   // Both outputs are 0/1 only outside reset, so the counters see reset cycles as idle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (stallF_o && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
         end
         if (flushD_o && !(&r_flush_cnt)) begin
            r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;
`else
   assign stall_cnt_o = '0;
   assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vectors, per-cycle model compare plus literal pins.
// Latency: model expects same-cycle controls and next-cycle timeout/counters.
// Backpressure: exercised through memory waits, timeout into HALT and reset recovery.
module tb_hazard_ctrl;

   localparam int RAW = 5;
   localparam int TMO = 4;
   localparam int CW  = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [RAW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic [1:0]     rsrcE;
   logic           rwM, rwW, pcs, mreq, mrdy;
   logic           stallF, stallD, stallE, stallM, flushD, flushE, flushW, tmo;
   logic [1:0]     fa, fb;
   logic [CW-1:0]  scnt, fcnt;

   int checks = 0;
   int errors = 0;

   // Model state: cycles the current access has waited, halt, sticky timeout, event counts.
   int m_waited = 0;
   bit m_halted = 0;
   bit m_timeout = 0;
   int m_stalls = 0;
   int m_flushes = 0;

   hazard_ctrl #(.REG_ADDR_WIDTH(RAW), .MEM_TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
      .clk_i(clk), .rst_i(rst),
      .rs1D_i(rs1D), .rs2D_i(rs2D), .rs1E_i(rs1E), .rs2E_i(rs2E),
      .rdE_i(rdE), .rdM_i(rdM), .rdW_i(rdW), .result_srcE_i(rsrcE),
      .reg_writeM_i(rwM), .reg_writeW_i(rwW), .pc_srcE_i(pcs),
      .mem_reqM_i(mreq), .mem_readyM_i(mrdy),
      .stallF_o(stallF), .stallD_o(stallD), .stallE_o(stallE), .stallM_o(stallM),
      .flushD_o(flushD), .flushE_o(flushE), .flushW_o(flushW),
      .forward_aE_o(fa), .forward_bE_o(fb), .timeout_o(tmo),
      .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int fwd(input int rs, input int rdm, input bit wm, input int rdw, input bit ww);
      if (wm && rdm != 0 && rdm == rs) return 2;
      if (ww && rdw != 0 && rdw == rs) return 1;
      return 0;
   endfunction

   // Per-cycle compare against the model, away from the rising edge.
   always @(negedge clk) begin
      int  e_fa, e_fb;
      bit  e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw, waiting, lu;
      int  maxc;
      maxc = (1 << CW) - 1;
      e_fa = 0; e_fb = 0;
      e_sf = 0; e_sd = 0; e_se = 0; e_sm = 0; e_fd = 0; e_fe = 0; e_fw = 0;
      waiting = mreq && !mrdy;
      lu = (rsrcE == 2'b01) && (rdE != 0) && (rdE == rs1D || rdE == rs2D);
      if (rst) begin
         e_fd = 1; e_fe = 1; e_fw = 1;
         m_waited = 0; m_halted = 0; m_timeout = 0; m_stalls = 0; m_flushes = 0;
      end else begin
         e_fa = fwd(int'(rs1E), int'(rdM), rwM, int'(rdW), rwW);
         e_fb = fwd(int'(rs2E), int'(rdM), rwM, int'(rdW), rwW);
         if (m_halted || waiting) begin
            e_sf = 1; e_sd = 1; e_se = 1; e_sm = 1; e_fw = 1;
         end else if (pcs) begin
            e_fd = 1; e_fe = 1;
         end else if (lu) begin
            e_sf = 1; e_sd = 1; e_fe = 1;
         end
      end
      chk("m_stallF", int'(stallF), int'(e_sf));
      chk("m_stallD", int'(stallD), int'(e_sd));
      chk("m_stallE", int'(stallE), int'(e_se));
      chk("m_stallM", int'(stallM), int'(e_sm));
      chk("m_flushD", int'(flushD), int'(e_fd));
      chk("m_flushE", int'(flushE), int'(e_fe));
      chk("m_flushW", int'(flushW), int'(e_fw));
      chk("m_fwdA", int'(fa), e_fa);
      chk("m_fwdB", int'(fb), e_fb);
      chk("m_timeout", int'(tmo), int'(m_timeout));
      chk("m_stall_cnt", int'(scnt), m_stalls);
      chk("m_flush_cnt", int'(fcnt), m_flushes);
      if (!rst) begin
         if (!m_halted) begin
            if (waiting) begin
               m_waited++;
               if (m_waited == TMO) begin
                  m_halted = 1;
                  m_timeout = 1;
               end
            end else begin
               m_waited = 0;
            end
         end
`ifdef HAZARD_PERF_EN
         if (e_sf && m_stalls < maxc) m_stalls++;
         if (e_fd && m_flushes < maxc) m_flushes++;
`endif
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0;
      rdE = '0; rdM = '0; rdW = '0; rsrcE = 2'b00;
      rwM = 0; rwW = 0; pcs = 0; mreq = 0; mrdy = 0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      cyc(); cyc();
      #2;
      chk("rst_flushD", int'(flushD), 1);
      chk("rst_stallF", int'(stallF), 0);
      chk("rst_timeout", int'(tmo), 0);

      cyc(); rst = 1'b0; idle(); #2;
      chk("idle_stallF", int'(stallF), 0);
      chk("idle_flushD", int'(flushD), 0);

      // Forwarding: M beats W; rdM=0 falls back to W; W alone on operand b.
      cyc(); rs1E = 5; rdM = 5; rwM = 1; rdW = 5; rwW = 1; rs2E = 7; #2;
      chk("fwd_a_M", int'(fa), 2);
      chk("fwd_b_none", int'(fb), 0);
      cyc(); rdM = 0; #2;
      chk("fwd_a_W_rdM0", int'(fa), 1);
      cyc(); rdM = 5; rwM = 0; rs2E = 5; #2;
      chk("fwd_b_W", int'(fb), 1);
      cyc(); rdW = 0; #2;
      chk("fwd_b_rdW0", int'(fb), 0);

      // Load-use for one cycle, then the bubble clears it.
      cyc(); idle(); rsrcE = 2'b01; rdE = 3; rs2D = 3; #2;
      chk("lu_stallF", int'(stallF), 1);
      chk("lu_stallD", int'(stallD), 1);
      chk("lu_flushE", int'(flushE), 1);
      chk("lu_stallE", int'(stallE), 0);
      cyc(); rsrcE = 2'b00; rdE = 0; #2;
      chk("lu_after_stallF", int'(stallF), 0);
      cyc(); rsrcE = 2'b01; rdE = 0; rs1D = 0; #2;
      chk("lu_x0_stallF", int'(stallF), 0);

      // Redirect wins over load-use.
      cyc(); idle(); rsrcE = 2'b01; rdE = 3; rs1D = 3; pcs = 1; #2;
      chk("br_flushD", int'(flushD), 1);
      chk("br_flushE", int'(flushE), 1);
      chk("br_stallF", int'(stallF), 0);

      // Three-cycle memory wait, release on fourth.
      cyc(); idle(); mreq = 1;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("mw_stallM", int'(stallM), 1);
         chk("mw_flushW", int'(flushW), 1);
         cyc();
      end
      mrdy = 1; #2;
      chk("mw_rel_stallF", int'(stallF), 0);
      chk("mw_rel_flushW", int'(flushW), 0);
      chk("mw_rel_timeout", int'(tmo), 0);

      // Redirect pending during a two-cycle wait applies only in the release cycle.
      cyc(); idle(); mreq = 1; pcs = 1; #2;
      chk("mwbr_flushD_wait", int'(flushD), 0);
      cyc(); #2;
      chk("mwbr_flushE_wait", int'(flushE), 0);
      cyc(); mrdy = 1; #2;
      chk("mwbr_flushD_rel", int'(flushD), 1);
      chk("mwbr_flushE_rel", int'(flushE), 1);
      chk("mwbr_stallF_rel", int'(stallF), 0);

      // Load-use applies in release cycle when no redirect.
      cyc(); idle(); mreq = 1; rsrcE = 2'b01; rdE = 9; rs2D = 9; #2;
      chk("mwlu_stallE_wait", int'(stallE), 1);
      cyc(); mrdy = 1; #2;
      chk("mwlu_stallD_rel", int'(stallD), 1);
      chk("mwlu_stallE_rel", int'(stallE), 0);
      chk("mwlu_flushE_rel", int'(flushE), 1);

      // Timeout: four waiting cycles, then HALT.
      cyc(); idle(); mreq = 1;
      repeat (3) cyc();
      #2;
      chk("to_not_yet", int'(tmo), 0);
      cyc(); mreq = 0; #2;
      chk("to_set", int'(tmo), 1);
      chk("halt_stallF", int'(stallF), 1);
      chk("halt_flushW", int'(flushW), 1);
      cyc(); pcs = 1; #2;
      chk("halt_stallM", int'(stallM), 1);
      chk("halt_no_flushD", int'(flushD), 0);

      // Reset mid-HALT recovers immediately.
      cyc(); idle(); rst = 1'b1; #2;
      chk("rst_halt_timeout", int'(tmo), 0);
      chk("rst_halt_stallF", int'(stallF), 0);
      cyc(); rst = 1'b0; #2;
      chk("post_rst_stallF", int'(stallF), 0);
      chk("post_rst_timeout", int'(tmo), 0);
      cyc(); rsrcE = 2'b01; rdE = 4; rs1D = 4; #2;
      chk("post_rst_lu", int'(stallF), 1);

      cyc(); idle();
      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
